// File: rtl/pkt_to_axis_buf.sv
// GMII receive bytes packed little-endian into DATA_BYTES-wide AXI-Stream beats,
// buffered in a show-ahead FIFO; frames that cannot fit are truncated or dropped whole.
module pkt_to_axis_buf #(
  parameter int DATA_BYTES = 1,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         axis_aclk,
  input  logic                         axis_aresetn,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_dv,
  input  logic                         rx_er,
  output logic [8*DATA_BYTES-1:0]      axis_tdata,
  output logic [DATA_BYTES-1:0]        axis_tkeep,
  output logic                         axis_tuser,
  output logic                         axis_tlast,
  output logic                         axis_tvalid,
  input  logic                         axis_tready,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int EW = DW + DATA_BYTES + 2;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      rx_byte_reg;
  logic            dv_reg, er_reg, line_idle_reg;
  logic [IW-1:0]   idx_reg, idx_next, cur_idx;
  logic [DW-1:0]   acc_reg, acc_next, word_acc;
  logic            err_reg, err_next, cur_err;
  logic            first_reg, first_next, cur_first;
  logic            wr_en_reg, wr_en_next;
  logic [EW-1:0]   wr_word_reg, wr_word_next;
  logic [CNT_W-1:0] frame_cnt_reg, err_cnt_reg, drop_cnt_reg;
  logic            frame_inc, err_inc, drop_inc, process, last_byte, word_done;
  logic [DATA_BYTES-1:0] keep_last, byte_sel;
  logic [AW:0]     wptr_reg, rptr_reg, rptr_next, level;
  logic [AW+1:0]   free_words;
  logic            pop, avail;
  logic [EW-1:0]   out_word_reg;
  logic            tvalid_reg;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  // Until rx_dv has been seen low after reset, any registered byte belongs to an abandoned frame.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rx_byte_reg   <= '0;
      dv_reg        <= 1'b0;
      er_reg        <= 1'b0;
      line_idle_reg <= 1'b0;
    end else begin
      rx_byte_reg <= rx_data;
      dv_reg      <= rx_dv;
      er_reg      <= rx_er;
      if (!rx_dv) line_idle_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      assign byte_sel[gi] = (cur_idx == IW'(gi));
      if (gi == 0) begin : g_first
        assign keep_last[gi] = 1'b1;
      end else begin : g_rest
        assign keep_last[gi] = (IW'(gi) <= cur_idx);
      end
    end
  endgenerate

  assign pop       = tvalid_reg & axis_tready;
  assign level     = wptr_reg - rptr_reg;
  // Space at the edge this word is written: the pending write is not yet in level, a pop this edge frees one.
  assign free_words = (AW+2)'(FIFO_DEPTH) - (AW+2)'(level) - (AW+2)'(wr_en_reg) + (AW+2)'(pop);
  assign last_byte = dv_reg & ~rx_dv;
  assign cur_idx   = (state_reg == IDLE) ? '0 : idx_reg;
  assign cur_err   = ((state_reg == IDLE) ? 1'b0 : err_reg) | er_reg;
  assign cur_first = (state_reg == IDLE) | first_reg;
  assign word_done = (cur_idx == IW'(DATA_BYTES-1)) | last_byte;

  always_comb begin
    word_acc = (cur_idx == '0) ? '0 : acc_reg;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (byte_sel[b]) word_acc[8*b +: 8] = rx_byte_reg;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    acc_next     = acc_reg;
    err_next     = err_reg;
    first_next   = first_reg;
    wr_en_next   = 1'b0;
    wr_word_next = wr_word_reg;
    frame_inc    = 1'b0;
    err_inc      = 1'b0;
    drop_inc     = 1'b0;
    process      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dv_reg) begin
          if (!line_idle_reg) begin
            state_next = DROP;
          end else begin
            state_next = RECV;
            process    = 1'b1;
          end
        end
      end
      RECV:    process = dv_reg;
      DROP:    if (!dv_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (process) begin
      err_next   = cur_err;
      idx_next   = cur_idx + IW'(1);
      acc_next   = word_acc;
      first_next = cur_first;
      if (word_done) begin
        idx_next   = '0;
        first_next = 1'b0;
        if (cur_first && free_words == '0) begin
          drop_inc   = 1'b1;
          state_next = DROP;
        end else if (!last_byte && free_words == (AW+2)'(1)) begin
          wr_en_next   = 1'b1;
          wr_word_next = {1'b1, 1'b1, {DATA_BYTES{1'b1}}, word_acc};
          drop_inc     = 1'b1;
          state_next   = DROP;
        end else begin
          wr_en_next   = 1'b1;
          wr_word_next = {last_byte & cur_err, last_byte,
                          last_byte ? keep_last : {DATA_BYTES{1'b1}}, word_acc};
          if (last_byte) begin
            state_next = IDLE;
            frame_inc  = 1'b1;
            err_inc    = cur_err;
          end
        end
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      acc_reg       <= '0;
      err_reg       <= 1'b0;
      first_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_word_reg   <= '0;
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      acc_reg       <= acc_next;
      err_reg       <= err_next;
      first_reg     <= first_next;
      wr_en_reg     <= wr_en_next;
      wr_word_reg   <= wr_word_next;
      frame_cnt_reg <= frame_cnt_reg + CNT_W'(frame_inc);
      err_cnt_reg   <= err_cnt_reg + CNT_W'(err_inc);
      drop_cnt_reg  <= drop_cnt_reg + CNT_W'(drop_inc);
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en_reg) mem[wptr_reg[AW-1:0]] <= wr_word_reg;
  end

  // The head entry stays counted in level until it is accepted downstream.
  assign rptr_next = rptr_reg + (AW+1)'(pop);
  assign avail     = (wptr_reg != rptr_next);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      tvalid_reg   <= 1'b0;
      out_word_reg <= '0;
    end else begin
      if (wr_en_reg) wptr_reg <= wptr_reg + (AW+1)'(1);
      rptr_reg <= rptr_next;
      if (!tvalid_reg || pop) begin
        tvalid_reg <= avail;
        if (avail) out_word_reg <= mem[rptr_next[AW-1:0]];
      end
    end
  end

  assign {axis_tuser, axis_tlast, axis_tkeep, axis_tdata} = out_word_reg;
  assign axis_tvalid = tvalid_reg;
  assign fifo_level  = level;
  assign frame_cnt   = frame_cnt_reg;
  assign err_cnt     = err_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_pkt_to_axis_buf.sv
// Directed bench: three instances (4-byte, 1-byte, and 1-byte with a 4-deep FIFO)
// driven from one shared GMII bus with per-instance rx_dv.
module tb_pkt_to_axis_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_er = 1'b0;
  logic dv4 = 1'b0, dv1 = 1'b0, dvs = 1'b0;
  logic tr4 = 1'b1, tr1 = 1'b1, trs = 1'b1;
  logic tog1 = 1'b0;

  logic [31:0] tdata4;
  logic [3:0]  tkeep4;
  logic        tuser4, tlast4, tv4;
  logic [15:0] fc4, ec4, dc4;
  logic [4:0]  lvl4;

  logic [7:0]  tdata1;
  logic [0:0]  tkeep1;
  logic        tuser1, tlast1, tv1;
  logic [15:0] fc1, ec1, dc1;
  logic [4:0]  lvl1;

  logic [7:0]  tdatas;
  logic [0:0]  tkeeps;
  logic        tusers, tlasts, tvs;
  logic [15:0] fcs, ecs, dcs;
  logic [2:0]  lvls;

  int tests = 0;
  int fails = 0;

  logic [79:0] q4[$];
  logic [79:0] q1[$];
  logic [79:0] qs[$];
  logic        hold1 = 1'b0;
  logic [79:0] held1 = '0;

  always #5 clk = ~clk;

  pkt_to_axis_buf #(.DATA_BYTES(4), .FIFO_DEPTH(16), .CNT_W(16)) dut4 (
    .axis_aclk(clk), .axis_aresetn(rst_n), .rx_data(rx_data), .rx_dv(dv4), .rx_er(rx_er),
    .axis_tdata(tdata4), .axis_tkeep(tkeep4), .axis_tuser(tuser4), .axis_tlast(tlast4),
    .axis_tvalid(tv4), .axis_tready(tr4), .frame_cnt(fc4), .err_cnt(ec4), .drop_cnt(dc4),
    .fifo_level(lvl4));

  pkt_to_axis_buf #(.DATA_BYTES(1), .FIFO_DEPTH(16), .CNT_W(16)) dut1 (
    .axis_aclk(clk), .axis_aresetn(rst_n), .rx_data(rx_data), .rx_dv(dv1), .rx_er(rx_er),
    .axis_tdata(tdata1), .axis_tkeep(tkeep1), .axis_tuser(tuser1), .axis_tlast(tlast1),
    .axis_tvalid(tv1), .axis_tready(tr1), .frame_cnt(fc1), .err_cnt(ec1), .drop_cnt(dc1),
    .fifo_level(lvl1));

  pkt_to_axis_buf #(.DATA_BYTES(1), .FIFO_DEPTH(4), .CNT_W(16)) duts (
    .axis_aclk(clk), .axis_aresetn(rst_n), .rx_data(rx_data), .rx_dv(dvs), .rx_er(rx_er),
    .axis_tdata(tdatas), .axis_tkeep(tkeeps), .axis_tuser(tusers), .axis_tlast(tlasts),
    .axis_tvalid(tvs), .axis_tready(trs), .frame_cnt(fcs), .err_cnt(ecs), .drop_cnt(dcs),
    .fifo_level(lvls));

  function automatic logic [79:0] beat(input logic [63:0] d, input logic [7:0] k,
                                       input logic l, input logic u);
    return {6'b0, u, l, k, d};
  endfunction

  function automatic logic [79:0] at4(input int i);
    return (i < q4.size()) ? q4[i] : '1;
  endfunction
  function automatic logic [79:0] at1(input int i);
    return (i < q1.size()) ? q1[i] : '1;
  endfunction
  function automatic logic [79:0] ats(input int i);
    return (i < qs.size()) ? qs[i] : '1;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beats are captured half a cycle before the edge that transfers them; a stalled beat must not change.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold1 = 1'b0;
    end else begin
      if (tv4 && tr4) q4.push_back(beat(64'(tdata4), 8'(tkeep4), tlast4, tuser4));
      if (tv1 && tr1) q1.push_back(beat(64'(tdata1), 8'(tkeep1), tlast1, tuser1));
      if (tvs && trs) qs.push_back(beat(64'(tdatas), 8'(tkeeps), tlasts, tusers));
      if (hold1) begin
        tests++;
        assert (tv1 === 1'b1 && beat(64'(tdata1), 8'(tkeep1), tlast1, tuser1) === held1) else begin
          fails++;
          $error("FAIL stall_hold observed=%0h expected=%0h",
                 {tv1, beat(64'(tdata1), 8'(tkeep1), tlast1, tuser1)}, {1'b1, held1});
        end
      end
      hold1 = tv1 && !tr1;
      held1 = beat(64'(tdata1), 8'(tkeep1), tlast1, tuser1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog1) tr1 = ~tr1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // mask = {dut4, dut1, duts}; one rx_dv=0 cycle follows, optionally with rx_er high.
  task automatic send(input int n, input logic [7:0] base, input int er_at,
                      input logic [2:0] mask, input logic gap_er);
    for (int i = 0; i < n; i++) begin
      rx_data = base + 8'(i);
      rx_er   = (i == er_at);
      {dv4, dv1, dvs} = mask;
      tick();
    end
    rx_data = '0;
    rx_er   = gap_er;
    {dv4, dv1, dvs} = 3'b000;
    tick();
    rx_er = 1'b0;
  endtask

  initial begin
    ticks(3);
    chk("rst_tvalid", 80'(tv4), 80'(0));
    chk("rst_tdata", 80'(tdata4), 80'(0));
    chk("rst_tkeep", 80'(tkeep4), 80'(0));
    chk("rst_level", 80'(lvl4), 80'(0));
    chk("rst_frame_cnt", 80'(fc4), 80'(0));
    chk("rst_drop_cnt", 80'(dc1), 80'(0));
    rst_n = 1'b1;
    ticks(2);

    // Latency: single-byte frame on the 1-byte instance, byte sampled at edge k.
    rx_data = 8'hAA;
    dv1 = 1'b1;
    @(posedge clk);
    #1;
    dv1 = 1'b0;
    rx_data = '0;
    @(negedge clk); chk("lat_k0", 80'(tv1), 80'(0));
    @(negedge clk); chk("lat_k1", 80'(tv1), 80'(0));
    @(negedge clk); chk("lat_k2", 80'(tv1), 80'(0));
    @(negedge clk); chk("lat_k3", 80'(tv1), 80'(1));
    ticks(3);
    chk("lat_beats", 80'(q1.size()), 80'(1));
    chk("lat_beat", at1(0), beat(64'hAA, 8'h1, 1'b1, 1'b0));
    q1.delete();

    // 6-byte frame into 4-byte words.
    send(6, 8'h01, -1, 3'b100, 1'b0);
    ticks(6);
    chk("w4_beats", 80'(q4.size()), 80'(2));
    chk("w4_beat0", at4(0), beat(64'h04030201, 8'hF, 1'b0, 1'b0));
    chk("w4_beat1", at4(1), beat(64'h00000605, 8'h3, 1'b1, 1'b0));
    chk("w4_frame_cnt", 80'(fc4), 80'(1));
    chk("w4_err_cnt", 80'(ec4), 80'(0));

    // Error on byte 3, with carrier-extension rx_er in the gap that follows.
    send(5, 8'h10, 2, 3'b010, 1'b1);
    ticks(6);
    chk("err_beats", 80'(q1.size()), 80'(5));
    for (int i = 0; i < 5; i++)
      chk($sformatf("err_beat%0d", i), at1(i),
          beat(64'(8'h10 + 8'(i)), 8'h1, i == 4, i == 4));
    chk("err_err_cnt", 80'(ec1), 80'(1));
    chk("err_frame_cnt", 80'(fc1), 80'(2));
    q1.delete();

    // 4-deep FIFO, no readout: truncation then a whole-frame drop.
    trs = 1'b0;
    send(10, 8'h40, -1, 3'b001, 1'b0);
    ticks(4);
    chk("ovf_level", 80'(lvls), 80'(4));
    chk("ovf_drop1", 80'(dcs), 80'(1));
    chk("ovf_frame_cnt", 80'(fcs), 80'(0));
    chk("ovf_head", 80'({tvs, tdatas}), 80'({1'b1, 8'h40}));
    send(3, 8'h60, -1, 3'b001, 1'b0);
    ticks(4);
    chk("ovf_drop2", 80'(dcs), 80'(2));
    chk("ovf_level2", 80'(lvls), 80'(4));
    trs = 1'b1;
    ticks(8);
    chk("ovf_beats", 80'(qs.size()), 80'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_beat%0d", i), ats(i),
          beat(64'(8'h40 + 8'(i)), 8'h1, i == 3, i == 3));
    chk("ovf_level0", 80'(lvls), 80'(0));
    send(2, 8'h70, -1, 3'b001, 1'b0);
    ticks(6);
    chk("ovf_after_beats", 80'(qs.size()), 80'(6));
    chk("ovf_after0", ats(4), beat(64'h70, 8'h1, 1'b0, 1'b0));
    chk("ovf_after1", ats(5), beat(64'h71, 8'h1, 1'b1, 1'b0));
    chk("ovf_after_fc", 80'(fcs), 80'(1));
    chk("ovf_after_dc", 80'(dcs), 80'(2));

    // Back-to-back frames, tready toggling every cycle.
    tog1 = 1'b1;
    send(3, 8'hA0, -1, 3'b010, 1'b1);
    send(3, 8'hB0, -1, 3'b010, 1'b0);
    ticks(16);
    tog1 = 1'b0;
    tr1 = 1'b1;
    ticks(4);
    chk("b2b_beats", 80'(q1.size()), 80'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("b2b_beat%0d", i), at1(i),
          beat(64'((i < 3) ? (8'hA0 + 8'(i)) : (8'hB0 + 8'(i - 3))), 8'h1,
               (i == 2) || (i == 5), 1'b0));
    chk("b2b_frame_cnt", 80'(fc1), 80'(4));
    chk("b2b_err_cnt", 80'(ec1), 80'(1));

    // Reset on byte 4 of an 8-byte frame while an earlier beat is stalled.
    q4.delete();
    tr4 = 1'b0;
    send(2, 8'h50, -1, 3'b100, 1'b0);
    ticks(5);
    chk("mid_pre_tvalid", 80'(tv4), 80'(1));
    chk("mid_pre_level", 80'(lvl4), 80'(1));
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h31 + 8'(i);
      dv4 = 1'b1;
      if (i == 3) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_tvalid", 80'(tv4), 80'(0));
        chk("mid_tdata", 80'({tlast4, tdata4}), 80'(0));
        chk("mid_level", 80'(lvl4), 80'(0));
        chk("mid_frame_cnt", 80'(fc4), 80'(0));
      end
      if (i == 4) rst_n = 1'b1;
      tick();
    end
    dv4 = 1'b0;
    rx_data = '0;
    tick();
    q4.delete();
    tr4 = 1'b1;
    ticks(8);
    chk("mid_no_beats", 80'(q4.size()), 80'(0));
    chk("mid_drop_cnt", 80'(dc4), 80'(0));
    chk("mid_frame_cnt2", 80'(fc4), 80'(0));
    send(5, 8'h21, -1, 3'b100, 1'b0);
    ticks(6);
    chk("mid_next_beats", 80'(q4.size()), 80'(2));
    chk("mid_next0", at4(0), beat(64'h24232221, 8'hF, 1'b0, 1'b0));
    chk("mid_next1", at4(1), beat(64'h00000025, 8'h1, 1'b1, 1'b0));
    chk("mid_next_fc", 80'(fc4), 80'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
